// File: rtl/address_map.vh
// Shared register-bus widths for the arbiter and the blocks hanging off it.
`ifndef ADDRESS_MAP_VH
`define ADDRESS_MAP_VH
`define DATA_WIDTH 8
`define ADDR_WIDTH 8
`endif

// File: rtl/reg_bus_arbiter.sv
// Two-master round-robin arbiter for the shared register bus (IDLE/STROBE/CAPTURE/ACK).
// Optional ARB_LOCK_EN adds i_m0_lock/i_m1_lock so an owner can keep the bus back-to-back.
`include "address_map.vh"

module reg_bus_arbiter (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_m0_req,
  input  logic [`ADDR_WIDTH-1:0] i_m0_addr,
  input  logic [`DATA_WIDTH-1:0] i_m0_wdata,
  input  logic                   i_m0_wr,
  input  logic                   i_m1_req,
  input  logic [`ADDR_WIDTH-1:0] i_m1_addr,
  input  logic [`DATA_WIDTH-1:0] i_m1_wdata,
  input  logic                   i_m1_wr,
`ifdef ARB_LOCK_EN
  input  logic                   i_m0_lock,
  input  logic                   i_m1_lock,
`endif
  output logic                   o_m0_gnt,
  output logic                   o_m1_gnt,
  output logic                   o_m0_ack,
  output logic                   o_m1_ack,
  output logic [`DATA_WIDTH-1:0] o_m0_rdata,
  output logic [`DATA_WIDTH-1:0] o_m1_rdata,
  output logic [`ADDR_WIDTH-1:0] o_addr_bus,
  output logic [`DATA_WIDTH-1:0] o_data_write_bus,
  output logic                   o_wr_enable_bus,
  input  logic [`DATA_WIDTH-1:0] i_data_read_bus,
  output logic                   o_busy
);

  typedef enum logic [1:0] {IDLE, STROBE, CAPTURE, ACK} state_t;

  state_t                          state, state_nx;
  logic [1:0]                      req;
  logic                            owner;    // last granted master; also the in-flight winner
  logic                            win, grant;
  logic                            wr_flg;
  logic [1:0][`DATA_WIDTH-1:0]     rdata;
`ifdef ARB_LOCK_EN
  logic                            lock_hold;
`endif

  assign req = {i_m1_req, i_m0_req};

  always_comb begin
    win = ~owner;
    if (req == 2'b01)      win = 1'b0;
    else if (req == 2'b10) win = 1'b1;
`ifdef ARB_LOCK_EN
    // lock only survives into the IDLE cycle directly after the owner's ack
    if (lock_hold && req[owner]) win = owner;
`endif
  end

  assign grant = (state == IDLE) && (|req);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (|req) state_nx = STROBE;
      STROBE:  state_nx = CAPTURE;
      CAPTURE: state_nx = ACK;
      ACK:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      owner            <= 1'b1;
      o_addr_bus       <= {`ADDR_WIDTH{1'b1}};
      o_data_write_bus <= '0;
      wr_flg           <= 1'b0;
      rdata            <= '0;
`ifdef ARB_LOCK_EN
      lock_hold        <= 1'b0;
`endif
    end else begin
      if (grant) begin
        owner            <= win;
        o_addr_bus       <= win ? i_m1_addr  : i_m0_addr;
        o_data_write_bus <= win ? i_m1_wdata : i_m0_wdata;
        wr_flg           <= win ? i_m1_wr    : i_m0_wr;
      end
      if (state == CAPTURE && !wr_flg) rdata[owner] <= i_data_read_bus;
`ifdef ARB_LOCK_EN
      lock_hold <= (state == ACK) && (owner ? i_m1_lock : i_m0_lock);
`endif
    end
  end

  assign o_busy          = (state != IDLE);
  assign o_m0_gnt        = o_busy & ~owner;
  assign o_m1_gnt        = o_busy &  owner;
  assign o_m0_ack        = (state == ACK) & ~owner;
  assign o_m1_ack        = (state == ACK) &  owner;
  assign o_wr_enable_bus = (state == STROBE) & wr_flg;
  assign o_m0_rdata      = rdata[0];
  assign o_m1_rdata      = rdata[1];

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Randomized bench for reg_bus_arbiter: transaction-level reference model plus a memory slave.
module tb_reg_bus_arbiter;
  logic       i_clk = 1'b0;
  logic       i_rst;
  logic [1:0] m_req, m_wr;
  logic [7:0] m_addr [2];
  logic [7:0] m_wdata [2];
`ifdef ARB_LOCK_EN
  logic [1:0] m_lock;
  bit         lk;
  int         lk_e;
`endif
  logic       o_m0_gnt, o_m1_gnt, o_m0_ack, o_m1_ack, o_wr_enable_bus, o_busy;
  logic [7:0] o_m0_rdata, o_m1_rdata, o_addr_bus, o_data_write_bus, i_data_read_bus;

  reg_bus_arbiter dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_m0_req(m_req[0]), .i_m0_addr(m_addr[0]), .i_m0_wdata(m_wdata[0]), .i_m0_wr(m_wr[0]),
    .i_m1_req(m_req[1]), .i_m1_addr(m_addr[1]), .i_m1_wdata(m_wdata[1]), .i_m1_wr(m_wr[1]),
`ifdef ARB_LOCK_EN
    .i_m0_lock(m_lock[0]), .i_m1_lock(m_lock[1]),
`endif
    .o_m0_gnt(o_m0_gnt), .o_m1_gnt(o_m1_gnt), .o_m0_ack(o_m0_ack), .o_m1_ack(o_m1_ack),
    .o_m0_rdata(o_m0_rdata), .o_m1_rdata(o_m1_rdata),
    .o_addr_bus(o_addr_bus), .o_data_write_bus(o_data_write_bus),
    .o_wr_enable_bus(o_wr_enable_bus), .i_data_read_bus(i_data_read_bus), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  // memory slave: unwritten locations read back addr^5A
  logic [7:0]   s_mem [256];
  logic [255:0] s_vld;
  always @(posedge i_clk or posedge i_rst)
    if (i_rst) s_vld <= '0;
    else if (o_wr_enable_bus) begin
      s_vld[o_addr_bus] <= 1'b1;
      s_mem[o_addr_bus] <= o_data_write_bus;
    end
  assign i_data_read_bus = s_vld[o_addr_bus] ? s_mem[o_addr_bus] : (o_addr_bus ^ 8'h5A);

  // reference model: one record per granted transaction, timed from its grant edge
  int         total = 0, bad = 0;
  int         e = 0, t_e, t_m, last, free_e;
  bit         t_valid, t_wr;
  logic [7:0] t_addr, exp_addr, exp_wdata;
  logic [7:0] exp_rd [2];
  logic [7:0] ref_mem [256];

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s edge=%0d got=%h exp=%h", tag, e, got, exp);
    end
  endtask

  task automatic model_reset();
    t_valid = 0; last = 1; free_e = 0;
    exp_addr = 8'hFF; exp_wdata = 8'h00; exp_rd[0] = 8'h00; exp_rd[1] = 8'h00;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'h5A;
`ifdef ARB_LOCK_EN
    lk = 0; lk_e = -1;
`endif
  endtask

  function automatic int phase();
    return t_valid ? e - t_e : 99;
  endfunction

  task automatic edge_step();
    int w;
    @(posedge i_clk);
    e++;
`ifdef ARB_LOCK_EN
    if (t_valid && e == t_e + 3) begin lk = m_lock[t_m]; lk_e = e + 1; end
`endif
    if (t_valid && e == t_e + 2 && !t_wr) exp_rd[t_m] = ref_mem[t_addr];
    if (e >= free_e && m_req != 2'b00) begin
      if (m_req == 2'b11) w = 1 - last;
      else                w = m_req[1] ? 1 : 0;
`ifdef ARB_LOCK_EN
      if (lk && lk_e == e && m_req[last]) w = last;
`endif
      t_valid = 1; t_e = e; t_m = w; last = w; free_e = e + 4;
      t_addr = m_addr[w]; t_wr = m_wr[w];
      exp_addr = m_addr[w]; exp_wdata = m_wdata[w];
      if (t_wr) ref_mem[t_addr] = m_wdata[w];
    end
  endtask

  task automatic check_outputs();
    int  ph;
    bit  act;
    ph  = phase();
    act = (ph >= 0 && ph <= 2);
    chk("gnt0",  8'(o_m0_gnt), 8'(act && t_m == 0));
    chk("gnt1",  8'(o_m1_gnt), 8'(act && t_m == 1));
    chk("ack0",  8'(o_m0_ack), 8'(ph == 2 && t_m == 0));
    chk("ack1",  8'(o_m1_ack), 8'(ph == 2 && t_m == 1));
    chk("wr_en", 8'(o_wr_enable_bus), 8'(ph == 0 && t_wr));
    chk("busy",  8'(o_busy), 8'(act));
    chk("addr",  o_addr_bus, exp_addr);
    chk("wdata", o_data_write_bus, exp_wdata);
    chk("rd0",   o_m0_rdata, exp_rd[0]);
    chk("rd1",   o_m1_rdata, exp_rd[1]);
  endtask

  task automatic new_txn(input int k);
    m_req[k]   = 1'b1;
    m_addr[k]  = 8'($urandom_range(15));
    m_wdata[k] = 8'($urandom);
    m_wr[k]    = 1'($urandom_range(1));
  endtask

  task automatic drive();
    int ph;
    ph = phase();
    for (int k = 0; k < 2; k++) begin
      if (m_req[k]) begin
        if (ph == 2 && t_m == k) begin
          if ($urandom_range(1) == 1) new_txn(k);
          else m_req[k] = 1'b0;
        end
      end else if ($urandom_range(2) == 0) new_txn(k);
    end
`ifdef ARB_LOCK_EN
    m_lock = 2'($urandom);
`endif
  endtask

  task automatic cycle();
    edge_step();
    @(negedge i_clk);
    check_outputs();
    drive();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // abort a transaction in CAPTURE with an async reset pulse between edges
  task automatic reset_mid();
    int n = 0;
    if (m_req == 2'b00) new_txn(0);
    while (phase() != 1 && n < 40) begin cycle(); n++; end
    chk("capture_found", 8'(n < 40), 8'd1);
    #1 i_rst = 1'b1;
    #1 model_reset();
    check_outputs();
    @(posedge i_clk); e++;
    @(negedge i_clk);
    check_outputs();
    i_rst = 1'b0;
  endtask

  initial begin
    i_rst = 1'b1;
    m_req = '0; m_wr = '0;
    for (int k = 0; k < 2; k++) begin m_addr[k] = '0; m_wdata[k] = '0; end
`ifdef ARB_LOCK_EN
    m_lock = '0;
`endif
    model_reset();
    #1 check_outputs();
    @(negedge i_clk);
    i_rst = 1'b0;
    m_req = 2'b11;
    m_addr[0] = 8'h05; m_wdata[0] = 8'hA5; m_wr[0] = 1'b1;
    m_addr[1] = 8'h10; m_wdata[1] = 8'h00; m_wr[1] = 1'b0;
    run(400);
    reset_mid();
    run(400);
    reset_mid();
    run(200);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/reg_bus_arbiter.md
REG_BUS_ARBITER -- requirements
Module: reg_bus_arbiter

Interface
REQ-001 Widths SHALL come from address_map.vh: `DATA_WIDTH (8), `ADDR_WIDTH (8); no module parameters.
REQ-002 i_clk  in  1  sole clock; all state updates on rising edge.
REQ-003 i_rst  in  1  reset, asynchronous, active-high.
REQ-004 i_m0_req, i_m1_req  in  1 each  master 0 (SPI controller) / master 1 (internal sequencer) transaction request.
REQ-005 i_m0_addr, i_m1_addr  in  ADDR_WIDTH  request address, held stable while req high.
REQ-006 i_m0_wdata, i_m1_wdata  in  DATA_WIDTH  write data, held stable while req high.
REQ-007 i_m0_wr, i_m1_wr  in  1  1=write, 0=read, held stable while req high.
REQ-008 o_m0_gnt, o_m1_gnt  out  1  master owns the bus (STROBE through ACK).
REQ-009 o_m0_ack, o_m1_ack  out  1  one-cycle completion pulse.
REQ-010 o_m0_rdata, o_m1_rdata  out  DATA_WIDTH  captured read data, valid from ack until that master's next ack.
REQ-011 o_addr_bus  out  ADDR_WIDTH; o_data_write_bus  out  DATA_WIDTH; o_wr_enable_bus  out  1; i_data_read_bus  in  DATA_WIDTH  shared register bus.
REQ-012 o_busy  out  1  high whenever state is not IDLE.

Function
REQ-013 FSM states SHALL be IDLE, STROBE, CAPTURE, ACK; IDLE->STROBE when any req high, STROBE->CAPTURE, CAPTURE->ACK, ACK->IDLE unconditionally.
REQ-014 In IDLE with exactly one req high, that master SHALL win; with both high, the master not granted last SHALL win (round-robin).
REQ-015 On IDLE->STROBE the winner's addr, wdata, wr SHALL be registered onto o_addr_bus, o_data_write_bus and an internal write flag; these bus outputs SHALL hold until the next grant.
REQ-016 o_wr_enable_bus SHALL be high for exactly the STROBE cycle, and only if the write flag is set; never high in any other state.
REQ-017 At the CAPTURE->ACK edge i_data_read_bus SHALL be registered into the winner's o_mN_rdata for reads; for writes o_mN_rdata SHALL be unchanged.
REQ-018 Winner's o_mN_gnt SHALL be high in STROBE, CAPTURE, ACK; the other gnt low; both low in IDLE.
REQ-019 Winner's o_mN_ack SHALL be high for the single ACK cycle only.
REQ-020 Latency: req sampled high at edge T -> STROBE in cycle T+1, ack high in cycle T+3, IDLE at T+4; minimum 4 cycles per transaction.
REQ-021 Masters SHALL drop req in the ack cycle; req still high in IDLE is a new transaction.
REQ-022 A req asserted by the losing master during any non-IDLE state SHALL be held pending and win the next IDLE arbitration.
REQ-023 Request inputs changing after grant SHALL not affect the in-flight transaction.

Reset
REQ-024 i_rst high SHALL immediately, without a clock edge, force IDLE, o_addr_bus=8'hFF, o_data_write_bus=8'h00, o_wr_enable_bus=0, all gnt/ack=0, both rdata=8'h00, o_busy=0, last-granted=master 1 (master 0 wins first contention).
REQ-025 Reset asserted mid-transaction SHALL abort it with no ack; after release, arbitration restarts from IDLE.

Configuration
REQ-026 Macro ARB_LOCK_EN: when defined, inputs i_m0_lock and i_m1_lock (1 bit each) SHALL exist; if the winner's lock is high in the ACK cycle and its req is high in the following IDLE, it SHALL win again regardless of round-robin.
REQ-027 Without ARB_LOCK_EN the lock ports SHALL not exist and arbitration SHALL be strictly per REQ-014.

Verification
REQ-028 m0 write addr 8'h05 data 8'hA5 -> o_wr_enable_bus high one cycle at T+1 with addr 05/data A5, o_m0_ack at T+3.
REQ-029 m1 read addr 8'h10, bus returns 8'h3C -> o_m1_rdata=8'h3C and o_m1_ack at T+3, o_wr_enable_bus never high.
REQ-030 Both req high from reset, held continuously -> grants alternate m0, m1, m0, m1 every 4 cycles.
REQ-031 i_rst pulsed during CAPTURE -> outputs at reset values asynchronously, no ack, addr bus 8'hFF.
REQ-032 ARB_LOCK_EN defined, m0 lock high, both req high -> three consecutive m0 grants; lock low -> m1 granted next.
REQ-033 m1 req raised during m0 STROBE -> m1 granted at first IDLE after m0 ack, m0 data unaffected.
